// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad lock controller and its timer.
package lock_pkg;

  typedef logic [3:0] digit_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ENTRY    = 3'd1,
    CHECK    = 3'd2,
    UNLOCKED = 3'd3,
    LOCKOUT  = 3'd4
  } state_t;

  // Star key: wipes a partial entry, never stored as a digit.
  localparam digit_t KEY_CLEAR  = 4'b1100;
  localparam int     NUM_DIGITS = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the entry, unlock and lockout phases.
// 'last' flags the cycle whose decrement ends the interval; the count saturates at 0.
module lock_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (en) begin
      if (load) begin
        count_reg <= load_val;
      end else if (dec && (count_reg != '0)) begin
        count_reg <= count_reg - ONE;
      end
    end
  end

  assign last = (count_reg <= ONE);

endmodule

// File: rtl/keypad_lock_ctrl.sv
// Passcode entry sequencer: collects four key digits, checks them, and drives
// a timed unlock or a lockout after repeated wrong codes.
module keypad_lock_ctrl
  import lock_pkg::*;
#(
  parameter logic [15:0] PASSCODE       = 16'h0965,
  parameter int          MAX_FAIL       = 3,
  parameter int          ENTRY_TIMEOUT  = 50_000_000,
  parameter int          UNLOCK_CYCLES  = 150_000_000,
  parameter int          LOCKOUT_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       unlock,
  output logic       locked_out,
  output logic       fail_pulse,
  output logic [2:0] digit_count,
  output logic [2:0] fail_count
);

  localparam int TW = $clog2(max3(ENTRY_TIMEOUT, UNLOCK_CYCLES, LOCKOUT_CYCLES)) + 1;
  localparam logic [TW-1:0] ENTRY_LOAD   = TW'(ENTRY_TIMEOUT);
  localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES);
  localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES);
  localparam logic [3:0]    MAX_FAIL_W   = 4'(MAX_FAIL);

  state_t state_reg, state_next;
  digit_t digit_buf_reg [NUM_DIGITS];
  logic [2:0] digit_count_reg, digit_count_next;
  logic [2:0] fail_count_reg, fail_count_next;
  logic locked_out_reg, locked_out_next;
  logic fail_evt_reg, fail_evt_next;
  logic unlock_reg, fail_pulse_reg;

  logic buf_clear, buf_wr;
  logic timer_load, timer_dec, timer_last;
  logic [TW-1:0] timer_load_val;
  logic [NUM_DIGITS-1:0] digit_match;
  logic code_ok, is_clear;
  logic [3:0] fail_count_inc;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_match
      assign digit_match[gi] = (digit_buf_reg[gi] == PASSCODE[(NUM_DIGITS-1-gi)*4 +: 4]);
    end
  endgenerate

  assign code_ok        = &digit_match;
  assign is_clear       = (key_code == KEY_CLEAR);
  assign fail_count_inc = {1'b0, fail_count_reg} + 4'd1;

  lock_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (timer_load),
    .load_val (timer_load_val),
    .dec      (timer_dec),
    .last     (timer_last)
  );

  always_comb begin
    state_next       = state_reg;
    digit_count_next = digit_count_reg;
    fail_count_next  = fail_count_reg;
    locked_out_next  = locked_out_reg;
    fail_evt_next    = 1'b0;
    buf_clear        = 1'b0;
    buf_wr           = 1'b0;
    timer_load       = 1'b0;
    timer_load_val   = '0;
    timer_dec        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (key_valid) begin
          if (is_clear) begin
            buf_clear        = 1'b1;
            digit_count_next = 3'd0;
          end else begin
            buf_wr           = 1'b1;
            digit_count_next = 3'd1;
            timer_load       = 1'b1;
            timer_load_val   = ENTRY_LOAD;
            state_next       = ENTRY;
          end
        end
      end

      ENTRY: begin
        // A key arriving in the expiry cycle is taken before the timeout is considered.
        if (key_valid) begin
          if (is_clear) begin
            buf_clear        = 1'b1;
            digit_count_next = 3'd0;
            timer_load       = 1'b1;
            state_next       = IDLE;
          end else begin
            buf_wr           = 1'b1;
            digit_count_next = digit_count_reg + 3'd1;
            timer_load       = 1'b1;
            timer_load_val   = ENTRY_LOAD;
            if (digit_count_reg == 3'(NUM_DIGITS - 1)) begin
              state_next = CHECK;
            end
          end
        end else begin
          timer_dec = 1'b1;
          if (timer_last) begin
            buf_clear        = 1'b1;
            digit_count_next = 3'd0;
            state_next       = IDLE;
          end
        end
      end

      CHECK: begin
        digit_count_next = 3'd0;
        buf_clear        = 1'b1;
        timer_load       = 1'b1;
        if (code_ok) begin
          fail_count_next = 3'd0;
          timer_load_val  = UNLOCK_LOAD;
          state_next      = UNLOCKED;
        end else if (fail_count_inc >= MAX_FAIL_W) begin
          fail_evt_next   = 1'b1;
          fail_count_next = MAX_FAIL_W[2:0];
          locked_out_next = 1'b1;
          timer_load_val  = LOCKOUT_LOAD;
          state_next      = LOCKOUT;
        end else begin
          fail_evt_next   = 1'b1;
          fail_count_next = fail_count_inc[2:0];
          state_next      = IDLE;
        end
      end

      UNLOCKED: begin
        timer_dec = 1'b1;
        if (timer_last) begin
          state_next = IDLE;
        end
      end

      LOCKOUT: begin
        timer_dec = 1'b1;
        if (timer_last) begin
          locked_out_next = 1'b0;
          fail_count_next = 3'd0;
          state_next      = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      digit_count_reg <= 3'd0;
      fail_count_reg  <= 3'd0;
      locked_out_reg  <= 1'b0;
      fail_evt_reg    <= 1'b0;
      unlock_reg      <= 1'b0;
      fail_pulse_reg  <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_buf_reg[i] <= '0;
      end
    end else begin
      // The verdict is staged once more so unlock/fail_pulse land two edges after the last key.
      fail_pulse_reg <= en & fail_evt_reg;
      if (en) begin
        state_reg       <= state_next;
        digit_count_reg <= digit_count_next;
        fail_count_reg  <= fail_count_next;
        locked_out_reg  <= locked_out_next;
        fail_evt_reg    <= fail_evt_next;
        unlock_reg      <= (state_reg == UNLOCKED);
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (buf_clear) begin
            digit_buf_reg[i] <= '0;
          end else if (buf_wr && (digit_count_reg[1:0] == 2'(i))) begin
            digit_buf_reg[i] <= key_code;
          end
        end
      end
    end
  end

  assign unlock      = unlock_reg;
  assign locked_out  = locked_out_reg;
  assign fail_pulse  = fail_pulse_reg;
  assign digit_count = digit_count_reg;
  assign fail_count  = fail_count_reg;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Directed bench for keypad_lock_ctrl with shortened timers.
module tb_keypad_lock_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic       key_valid;
  logic [3:0] key_code;
  logic       unlock;
  logic       locked_out;
  logic       fail_pulse;
  logic [2:0] digit_count;
  logic [2:0] fail_count;

  int total = 0;
  int bad   = 0;

  keypad_lock_ctrl #(
    .PASSCODE       (16'h0965),
    .MAX_FAIL       (3),
    .ENTRY_TIMEOUT  (20),
    .UNLOCK_CYCLES  (10),
    .LOCKOUT_CYCLES (30)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .unlock      (unlock),
    .locked_out  (locked_out),
    .fail_pulse  (fail_pulse),
    .digit_count (digit_count),
    .fail_count  (fail_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic press(input logic [3:0] code);
    key_code  = code;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    $display("t=%0t key=%b en=%0b digit_count=%0d", $time, code, en, digit_count);
  endtask

  task automatic enter_code(input logic [15:0] code, input int spacing);
    logic [3:0] d;
    for (int i = 0; i < 4; i++) begin
      d = code[15-4*i -: 4];
      press(d);
      if (i < 3) idle(spacing - 1);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; key_valid = 1'b0; key_code = 4'h0;
    idle(2);
    chk1("rst_unlock", unlock, 1'b0);
    chk1("rst_locked_out", locked_out, 1'b0);
    chk1("rst_fail_pulse", fail_pulse, 1'b0);
    chk3("rst_digit_count", digit_count, 3'd0);
    chk3("rst_fail_count", fail_count, 3'd0);
    rst = 1'b0;
    tick();

    // 1: correct code, keys 3 cycles apart
    enter_code(16'h0965, 3);
    chk3("t1_count4", digit_count, 3'd4);
    chk1("t1_unlock_k0", unlock, 1'b0);
    tick();
    chk1("t1_unlock_k1", unlock, 1'b0);
    chk3("t1_count_cleared", digit_count, 3'd0);
    tick();
    chk1("t1_unlock_k2", unlock, 1'b1);
    idle(9);
    chk1("t1_unlock_last", unlock, 1'b1);
    tick();
    chk1("t1_unlock_off", unlock, 1'b0);
    chk3("t1_fail_count", fail_count, 3'd0);

    // 2: one wrong code
    enter_code(16'h0964, 1);
    tick();
    chk1("t2_pulse_k1", fail_pulse, 1'b0);
    chk3("t2_fail_count", fail_count, 3'd1);
    tick();
    chk1("t2_pulse_k2", fail_pulse, 1'b1);
    chk1("t2_unlock", unlock, 1'b0);
    tick();
    chk1("t2_pulse_end", fail_pulse, 1'b0);
    chk3("t2_digit_count", digit_count, 3'd0);

    // 3: two more wrong codes reach the lockout
    enter_code(16'h1234, 1);
    idle(3);
    chk3("t3_fail_count2", fail_count, 3'd2);
    enter_code(16'h0000, 1);
    tick();
    chk1("t3_locked", locked_out, 1'b1);
    chk3("t3_fail_count3", fail_count, 3'd3);
    tick();
    chk1("t3_pulse", fail_pulse, 1'b1);
    enter_code(16'h0965, 1);
    idle(2);
    chk1("t3_unlock_ignored", unlock, 1'b0);
    chk3("t3_keys_ignored", digit_count, 3'd0);
    idle(22);
    chk1("t3_locked_last", locked_out, 1'b1);
    tick();
    chk1("t3_locked_off", locked_out, 1'b0);
    chk3("t3_fail_count_clr", fail_count, 3'd0);
    enter_code(16'h0965, 1);
    idle(2);
    chk1("t3_unlock_after", unlock, 1'b1);
    idle(10);
    chk1("t3_unlock_off", unlock, 1'b0);

    // 4: entry timeout after two digits
    press(4'h0);
    press(4'h9);
    chk3("t4_count2", digit_count, 3'd2);
    idle(19);
    chk3("t4_count_before_to", digit_count, 3'd2);
    tick();
    chk3("t4_count_timeout", digit_count, 3'd0);
    enter_code(16'h0965, 1);
    idle(2);
    chk1("t4_unlock", unlock, 1'b1);
    chk3("t4_fail_count", fail_count, 3'd0);
    chk1("t4_no_pulse", fail_pulse, 1'b0);
    idle(10);
    chk1("t4_unlock_off", unlock, 1'b0);

    // 5: clear key mid-entry, then correct code
    press(4'h0);
    press(4'h9);
    press(4'hC);
    chk3("t5_count_clear", digit_count, 3'd0);
    enter_code(16'h0965, 1);
    idle(2);
    chk1("t5_unlock", unlock, 1'b1);

    // 6: en low for 5 cycles stretches unlock to 15 cycles
    en = 1'b0;
    idle(5);
    chk1("t6_unlock_frozen", unlock, 1'b1);
    en = 1'b1;
    idle(9);
    chk1("t6_unlock_15th", unlock, 1'b1);
    tick();
    chk1("t6_unlock_off", unlock, 1'b0);

    // 6b: reset during UNLOCKED drops unlock on the next edge
    enter_code(16'h0965, 1);
    idle(3);
    chk1("t6_unlock_pre_rst", unlock, 1'b1);
    rst = 1'b1;
    tick();
    chk1("t6_rst_unlock", unlock, 1'b0);
    rst = 1'b0;
    idle(2);
    chk1("t6_post_rst_unlock", unlock, 1'b0);

    // keys ignored while en is low
    en = 1'b0;
    press(4'h0);
    chk3("en_low_key", digit_count, 3'd0);
    en = 1'b1;
    press(4'h0);
    chk3("en_high_key", digit_count, 3'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
